// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: glitch-free CPU clock source for the tc140l core.
// Run mode produces a free-running square wave. Step mode produces one
// clock pulse per debounced push-button press. A 16-bit count of cpu_clk
// rising edges is exported for the display mux.
module cpu_clock_ctrl #(
    parameter int CLK_HZ           = 50_000_000,
    parameter int RUN_HZ           = 1,
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int STEP_HIGH_CYCLES = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run_mode,
    input  logic        step_n,
    output logic        cpu_clk,
    output logic        cpu_tick,
    output logic        step_busy,
    output logic [15:0] tick_count
);

    localparam int HALF      = CLK_HZ / (2 * RUN_HZ);
    localparam int PHASE_MAX = (HALF > STEP_HIGH_CYCLES) ? HALF : STEP_HIGH_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX) + 1;
    localparam int DW        = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_HIGH_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    logic [1:0]    run_sync;
    logic [1:0]    step_sync;
    logic          run_s;
    logic          step_s;

    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          db_hit;
    logic          press;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          mode;
    logic          mode_nxt;
    logic          pending;
    logic          pending_nxt;
    logic          rise;

    assign run_s  = run_sync[1];
    assign step_s = step_sync[1];

    // Two-flop synchronizers for the asynchronous switch and button; both rest at "released".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_sync  <= 2'b11;
            step_sync <= 2'b11;
        end else begin
            run_sync  <= {run_sync[0], run_mode};
            step_sync <= {step_sync[0], step_n};
        end
    end

    // The accepted level flips on the last of DEBOUNCE_CYCLES consecutive differing samples.
    assign db_hit = (step_s != db_level) && (db_cnt == DB_LAST);
    assign press  = db_hit && db_level;

    // Debounce counter: any sample matching the accepted level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (step_s == db_level) begin
            db_cnt   <= '0;
        end else if (db_hit) begin
            db_level <= step_s;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + DW'(1);
        end
    end

    // Next-state logic: the mode is only re-latched in LOW, so a HIGH phase always runs to length.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mode_nxt    = mode;
        pending_nxt = pending;
        rise        = 1'b0;

        if (run_s) begin
            pending_nxt = 1'b0;
        end else if (press) begin
            pending_nxt = 1'b1;
        end

        case (state)
            LOW: begin
                mode_nxt = run_s;
                if (run_s ? (cnt >= HALF_LAST) : pending) begin
                    state_nxt   = HIGH;
                    cnt_nxt     = '0;
                    rise        = 1'b1;
                    pending_nxt = 1'b0;
                end else if (cnt < HALF_LAST) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (cnt == (mode ? HALF_LAST : STEP_LAST)) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, phase counter, tick strobe and tick counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LOW;
            cnt        <= '0;
            mode       <= 1'b1;
            pending    <= 1'b0;
            cpu_tick   <= 1'b0;
            tick_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mode     <= mode_nxt;
            pending  <= pending_nxt;
            cpu_tick <= rise;
            if (rise) begin
                tick_count <= tick_count + 16'd1;
            end
        end
    end

    assign cpu_clk   = (state == HIGH);
    assign step_busy = pending | ((state == HIGH) & ~mode);

endmodule
